// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and constants for the I2C target endpoint.
//   I2C_BYTE_W  - bits per I2C byte
//   I2C_CNT_W   - width of the per-byte bit counter
//   i2c_state_e - target FSM states
package i2c_pkg;

    localparam int unsigned I2C_BYTE_W = 8;
    localparam int unsigned I2C_CNT_W  = $clog2(I2C_BYTE_W);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK,
        ST_IGNORE
    } i2c_state_e;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: SYNC-stage synchronizer plus one history flop for an
// asynchronous bus line, producing the synced level and single-cycle
// rise/fall events.
//   clk_i   - system clock
//   rst_i   - asynchronous active-high reset (line assumed idle high)
//   line_i  - raw pin
//   level_o - synchronized level
//   rise_o  - one-cycle strobe on a 0->1 transition of level_o
//   fall_o  - one-cycle strobe on a 1->0 transition of level_o
module i2c_line_sync #(
    parameter int unsigned SYNC = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic line_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC-1:0] sync_q;
    logic            hist_q;

    // Reset to the idle-high bus level so reset release creates no edge.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '1;
            hist_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[SYNC-2:0], line_i};
            hist_q <= sync_q[SYNC-1];
        end
    end

    assign level_o = sync_q[SYNC-1];
    assign rise_o  = sync_q[SYNC-1] & ~hist_q;
    assign fall_o  = ~sync_q[SYNC-1] & hist_q;

endmodule

// File: rtl/i2c_slave.sv
// i2c_slave: I2C target answering one 7-bit address. Oversamples SDA/SCL,
// detects START/repeated START/STOP, ACKs its address and every written
// byte, strobes write bytes out and shifts fabric-supplied read bytes in.
//   clk, reset         - system clock (>=20x SCL), async active-high reset
//   sda (inout), scl   - open-drain bus lines (SDA driven 0 or z only)
//   busy               - addressed START until STOP
//   rw                 - latched R/W bit of the current transfer (1 = read)
//   rxdata, rxvalid    - last written byte and its one-cycle strobe
//   txreq, txdata      - next-read-byte request strobe and the byte itself
//   start_det,stop_det - one-cycle bus condition strobes
module i2c_slave
    import i2c_pkg::*;
#(
    parameter logic [6:0]  ADDR = 7'h50,
    parameter int unsigned SYNC = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire                   sda,
    input  logic                  scl,
    output logic                  busy,
    output logic                  rw,
    output logic [I2C_BYTE_W-1:0] rxdata,
    output logic                  rxvalid,
    output logic                  txreq,
    input  logic [I2C_BYTE_W-1:0] txdata,
    output logic                  start_det,
    output logic                  stop_det
);

    logic sda_lvl, sda_rise, sda_fall;
    logic scl_lvl, scl_rise, scl_fall;

    i2c_line_sync #(.SYNC(SYNC)) u_sda_sync (
        .clk_i(clk), .rst_i(reset), .line_i(sda),
        .level_o(sda_lvl), .rise_o(sda_rise), .fall_o(sda_fall)
    );

    i2c_line_sync #(.SYNC(SYNC)) u_scl_sync (
        .clk_i(clk), .rst_i(reset), .line_i(scl),
        .level_o(scl_lvl), .rise_o(scl_rise), .fall_o(scl_fall)
    );

    i2c_state_e             state_q, state_d;
    logic [I2C_CNT_W-1:0]   cnt_q, cnt_d;
    // Only 7 bits are stored: the incoming bit completes the byte, and on
    // reads the MSB goes straight to the SDA driver when txdata is loaded.
    logic [I2C_BYTE_W-2:0]  shift_q, shift_d;
    logic                   oe_q, oe_d;     // 1 = pull SDA low
    logic                   load_q, load_d; // next scl_fall loads txdata
    logic                   busy_q, busy_d, rw_q, rw_d;
    logic [I2C_BYTE_W-1:0]  rxdata_q, rxdata_d;
    logic                   rxvalid_q, rxvalid_d, txreq_q, txreq_d;
    logic                   start_q, start_d, stop_q, stop_d;
    logic [I2C_BYTE_W-1:0]  byte_in;
    logic                   scl_hi, start_ev, stop_ev;

    assign byte_in  = {shift_q, sda_lvl};
    // SCL counts as high in the cycle it falls, so a coincident bus
    // condition wins and that scl_fall is dropped.
    assign scl_hi   = scl_lvl | scl_fall;
    assign start_ev = sda_fall & scl_hi;
    assign stop_ev  = sda_rise & scl_hi;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            shift_q   <= '0;
            oe_q      <= 1'b0;
            load_q    <= 1'b0;
            busy_q    <= 1'b0;
            rw_q      <= 1'b0;
            rxdata_q  <= '0;
            rxvalid_q <= 1'b0;
            txreq_q   <= 1'b0;
            start_q   <= 1'b0;
            stop_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            shift_q   <= shift_d;
            oe_q      <= oe_d;
            load_q    <= load_d;
            busy_q    <= busy_d;
            rw_q      <= rw_d;
            rxdata_q  <= rxdata_d;
            rxvalid_q <= rxvalid_d;
            txreq_q   <= txreq_d;
            start_q   <= start_d;
            stop_q    <= stop_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        shift_d   = shift_q;
        oe_d      = oe_q;
        load_d    = load_q;
        busy_d    = busy_q;
        rw_d      = rw_q;
        rxdata_d  = rxdata_q;
        rxvalid_d = 1'b0;
        txreq_d   = 1'b0;
        start_d   = 1'b0;
        stop_d    = 1'b0;

        if (start_ev) begin
            state_d = ST_ADDR;
            cnt_d   = '1;
            oe_d    = 1'b0;
            load_d  = 1'b0;
            start_d = 1'b1;
        end else if (stop_ev) begin
            state_d = ST_IDLE;
            oe_d    = 1'b0;
            load_d  = 1'b0;
            busy_d  = 1'b0;
            stop_d  = 1'b1;
        end else begin
            unique case (state_q)
                ST_ADDR: if (scl_rise) begin
                    shift_d = byte_in[I2C_BYTE_W-2:0];
                    if (cnt_q == '0) begin
                        if (byte_in[7:1] == ADDR) begin
                            rw_d    = byte_in[0];
                            busy_d  = 1'b1;
                            state_d = ST_ADDR_ACK;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                // The ACK is asserted on the first scl_fall; on the ACK
                // scl_rise a read hands over to RD_DATA (whose first fall
                // replaces the ACK with bit 7), a write lets WR_ACK release.
                ST_ADDR_ACK: begin
                    if (scl_fall && !oe_q) begin
                        oe_d = 1'b1;
                    end else if (scl_rise && oe_q) begin
                        if (rw_q) begin
                            txreq_d = 1'b1;
                            load_d  = 1'b1;
                            state_d = ST_RD_DATA;
                        end else begin
                            state_d = ST_WR_ACK;
                        end
                    end
                end
                ST_WR_DATA: if (scl_rise) begin
                    shift_d = byte_in[I2C_BYTE_W-2:0];
                    if (cnt_q == '0) begin
                        rxdata_d  = byte_in;
                        rxvalid_d = 1'b1;
                        state_d   = ST_WR_ACK;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_WR_ACK: if (scl_fall) begin
                    if (!oe_q) begin
                        oe_d = 1'b1;
                    end else begin
                        oe_d    = 1'b0;
                        cnt_d   = '1;
                        state_d = ST_WR_DATA;
                    end
                end
                ST_RD_DATA: if (scl_fall) begin
                    if (load_q) begin
                        shift_d = txdata[I2C_BYTE_W-2:0];
                        oe_d    = ~txdata[I2C_BYTE_W-1];
                        cnt_d   = '1;
                        load_d  = 1'b0;
                    end else if (cnt_q == '0) begin
                        oe_d    = 1'b0;
                        state_d = ST_RD_ACK;
                    end else begin
                        shift_d = {shift_q[I2C_BYTE_W-3:0], 1'b0};
                        oe_d    = ~shift_q[I2C_BYTE_W-2];
                        cnt_d   = cnt_q - 1'b1;
                    end
                end
                ST_RD_ACK: if (scl_rise) begin
                    if (!sda_lvl) begin
                        txreq_d = 1'b1;
                        load_d  = 1'b1;
                        state_d = ST_RD_DATA;
                    end else begin
                        state_d = ST_IGNORE;
                    end
                end
                default: ;
            endcase
        end
    end

    assign sda       = oe_q ? 1'b0 : 1'bz;
    assign busy      = busy_q;
    assign rw        = rw_q;
    assign rxdata    = rxdata_q;
    assign rxvalid   = rxvalid_q;
    assign txreq     = txreq_q;
    assign start_det = start_q;
    assign stop_det  = stop_q;

endmodule

// File: tb/tb_i2c_slave.sv
module tb_i2c_slave;
    import i2c_pkg::*;

    localparam int Q = 100; // quarter SCL period = 10 clk

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl = 1'b1;
    logic       m_low = 1'b0;
    logic [7:0] txdata = 8'h00;
    wire        sda;
    logic       busy, rw, rxvalid, txreq, start_det, stop_det;
    logic [7:0] rxdata;

    int checks = 0;
    int failures = 0;
    int n_rxv = 0, n_txr = 0, n_start = 0, n_stop = 0, n_drv = 0;

    assign sda = m_low ? 1'b0 : 1'bz;
    pullup (sda);

    always #5 clk = ~clk;

    i2c_slave #(.ADDR(7'h50), .SYNC(2)) dut (
        .clk(clk), .reset(reset), .sda(sda), .scl(scl),
        .busy(busy), .rw(rw), .rxdata(rxdata), .rxvalid(rxvalid),
        .txreq(txreq), .txdata(txdata),
        .start_det(start_det), .stop_det(stop_det)
    );

    always @(negedge clk) begin
        if (rxvalid)   n_rxv++;
        if (txreq)     n_txr++;
        if (start_det) n_start++;
        if (stop_det)  n_stop++;
        if (!m_low && sda !== 1'b1) n_drv++;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- bus master primitives ----------------
    task automatic sbit(input logic b);
        m_low = ~b; #Q; scl = 1'b1; #(2*Q); scl = 1'b0; #Q;
    endtask

    task automatic rbit(output logic b);
        m_low = 1'b0; #Q; scl = 1'b1; #Q; b = sda; #Q; scl = 1'b0; #Q;
    endtask

    task automatic send_byte(input logic [7:0] v, output logic ack);
        for (int i = 7; i >= 0; i--) sbit(v[i]);
        rbit(ack);
    endtask

    task automatic recv_bits(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin
            rbit(b);
            v[i] = b;
        end
    endtask

    task automatic bus_start();
        m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_rstart();
        m_low = 1'b0; #Q; scl = 1'b1; #Q; m_low = 1'b1; #Q; scl = 1'b0; #Q;
    endtask

    task automatic bus_stop();
        m_low = 1'b1; #Q; scl = 1'b1; #Q; m_low = 1'b0; #Q;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        #33;
        checks++;
        if ({busy, rw, rxdata, rxvalid, txreq, start_det, stop_det} !== 14'h0) begin
            failures++;
            $display("FAIL reset_outputs: got %b required %b",
                     {busy, rw, rxdata, rxvalid, txreq, start_det, stop_det}, 14'h0);
        end
        checks++;
        if (sda !== 1'b1) begin
            failures++;
            $display("FAIL reset_sda: got %b required 1", sda);
        end
        @(negedge clk); reset = 1'b0;
        #Q;
    endtask

    task automatic test_write();
        logic ack;
        int rxv0, st0, sp0;
        rxv0 = n_rxv; st0 = n_start; sp0 = n_stop;
        bus_start();
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL write_addr_ack: got %b required 0", ack); end
        send_byte(8'h3C, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL write_data_ack: got %b required 0", ack); end
        checks++;
        if (busy !== 1'b1) begin failures++; $display("FAIL write_busy_mid: got %b required 1", busy); end
        checks++;
        if (rw !== 1'b0) begin failures++; $display("FAIL write_rw: got %b required 0", rw); end
        bus_stop();
        #Q;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL write_busy_end: got %b required 0", busy); end
        checks++;
        if (n_rxv - rxv0 != 1) begin failures++; $display("FAIL write_rxvalid_count: got %0d required 1", n_rxv - rxv0); end
        checks++;
        if (rxdata !== 8'h3C) begin failures++; $display("FAIL write_rxdata: got %h required 3c", rxdata); end
        checks++;
        if (n_start - st0 != 1) begin failures++; $display("FAIL write_start_count: got %0d required 1", n_start - st0); end
        checks++;
        if (n_stop - sp0 != 1) begin failures++; $display("FAIL write_stop_count: got %0d required 1", n_stop - sp0); end
    endtask

    task automatic test_addr_miss();
        logic ack;
        int rxv0, txr0, drv0;
        rxv0 = n_rxv; txr0 = n_txr; drv0 = n_drv;
        bus_start();
        send_byte(8'hA2, ack);
        checks++;
        if (ack !== 1'b1) begin failures++; $display("FAIL miss_ack: got %b required 1", ack); end
        send_byte(8'h55, ack);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL miss_busy: got %b required 0", busy); end
        bus_stop();
        #Q;
        checks++;
        if (n_drv - drv0 != 0) begin failures++; $display("FAIL miss_sda_driven: got %0d cycles required 0", n_drv - drv0); end
        checks++;
        if (n_rxv - rxv0 != 0) begin failures++; $display("FAIL miss_rxvalid: got %0d required 0", n_rxv - rxv0); end
        checks++;
        if (n_txr - txr0 != 0) begin failures++; $display("FAIL miss_txreq: got %0d required 0", n_txr - txr0); end
    endtask

    task automatic test_read();
        logic ack;
        logic [7:0] v;
        int txr0, drv0;
        txr0 = n_txr;
        txdata = 8'hA5;
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0) begin failures++; $display("FAIL read_addr_ack: got %b required 0", ack); end
        recv_bits(v);
        checks++;
        if (v !== 8'hA5) begin failures++; $display("FAIL read_byte0: got %h required a5", v); end
        txdata = 8'h0F;
        sbit(1'b0);
        recv_bits(v);
        checks++;
        if (v !== 8'h0F) begin failures++; $display("FAIL read_byte1: got %h required 0f", v); end
        sbit(1'b1);
        drv0 = n_drv;
        checks++;
        if (n_txr - txr0 != 2) begin failures++; $display("FAIL read_txreq_count: got %0d required 2", n_txr - txr0); end
        checks++;
        if (rw !== 1'b1 || busy !== 1'b1) begin
            failures++; $display("FAIL read_rw_busy: got rw=%b busy=%b required rw=1 busy=1", rw, busy);
        end
        #(4*Q);
        bus_stop();
        #Q;
        checks++;
        if (n_drv - drv0 != 0) begin failures++; $display("FAIL read_release_after_nack: got %0d cycles required 0", n_drv - drv0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL read_busy_end: got %b required 0", busy); end
    endtask

    task automatic test_repeated_start();
        logic ack;
        logic [7:0] v;
        int st0;
        st0 = n_start;
        bus_start();
        send_byte(8'hA0, ack);
        send_byte(8'h12, ack);
        checks++;
        if (rw !== 1'b0) begin failures++; $display("FAIL rs_rw_write: got %b required 0", rw); end
        txdata = 8'h5A;
        bus_rstart();
        send_byte(8'hA1, ack);
        checks++;
        if (ack !== 1'b0 || rw !== 1'b1) begin
            failures++; $display("FAIL rs_read_addr: got ack=%b rw=%b required ack=0 rw=1", ack, rw);
        end
        recv_bits(v);
        sbit(1'b1);
        checks++;
        if (v !== 8'h5A) begin failures++; $display("FAIL rs_read_byte: got %h required 5a", v); end
        bus_stop();
        #Q;
        checks++;
        if (n_start - st0 != 2) begin failures++; $display("FAIL rs_start_count: got %0d required 2", n_start - st0); end
        checks++;
        if (rxdata !== 8'h12) begin failures++; $display("FAIL rs_rxdata: got %h required 12", rxdata); end
    endtask

    task automatic test_stop_mid_byte();
        logic ack;
        int rxv0;
        rxv0 = n_rxv;
        bus_start();
        send_byte(8'hA0, ack);
        sbit(1'b1); sbit(1'b0); sbit(1'b1); sbit(1'b1);
        bus_stop();
        #Q;
        checks++;
        if (n_rxv - rxv0 != 0) begin failures++; $display("FAIL mid_rxvalid: got %0d required 0", n_rxv - rxv0); end
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL mid_busy: got %b required 0", busy); end
        checks++;
        if (dut.state_q !== ST_IDLE) begin failures++; $display("FAIL mid_state: got %0d required %0d", dut.state_q, ST_IDLE); end
        checks++;
        if (rxdata !== 8'h12) begin failures++; $display("FAIL mid_rxdata: got %h required 12", rxdata); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        txdata = 8'h00;
        bus_start();
        send_byte(8'hA1, ack);
        checks++;
        if (sda !== 1'b0) begin failures++; $display("FAIL rst_bit_driven: got %b required 0", sda); end
        @(negedge clk); #1;
        reset = 1'b1;
        #1;
        checks++;
        if (sda !== 1'b1) begin failures++; $display("FAIL rst_sda_release: got %b required 1", sda); end
        checks++;
        if ({busy, rw, rxdata, rxvalid, txreq, start_det, stop_det} !== 14'h0) begin
            failures++;
            $display("FAIL rst_outputs: got %b required %b",
                     {busy, rw, rxdata, rxvalid, txreq, start_det, stop_det}, 14'h0);
        end
        #20;
        @(negedge clk); reset = 1'b0;
        #Q;
        scl = 1'b1;
        #Q;
        bus_start();
        send_byte(8'hA0, ack);
        checks++;
        if (ack !== 1'b0 || busy !== 1'b1) begin
            failures++; $display("FAIL rst_reack: got ack=%b busy=%b required ack=0 busy=1", ack, busy);
        end
        bus_stop();
        #Q;
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL rst_final_busy: got %b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_addr_miss();
        test_read();
        test_repeated_start();
        test_stop_mid_byte();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
